// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM state, RV32I
// size/sign encodings and the default bus timeout.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } lsu_state_t;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  localparam int unsigned LSU_TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/lsu_lane_extract.sv
// Load-side lane extraction: selects the byte/halfword addressed by the low
// address bits and sign- or zero-extends it to 32 bits.
module lsu_lane_extract
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  assign lane_byte = rdata[{offset, 3'b000} +: 8];
  assign lane_half = offset[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    result = '0;
    case (funct3)
      LSU_B:   result = {{24{lane_byte[7]}}, lane_byte};
      LSU_BU:  result = {24'h0, lane_byte};
      LSU_H:   result = {{16{lane_half[15]}}, lane_half};
      LSU_HU:  result = {16'h0, lane_half};
      LSU_W:   result = rdata;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/lsu_stage.sv
// Single-outstanding load/store unit driving a Wishbone-style bus.
// Optional LSU_MISALIGN_TRAP_EN traps misaligned H/W accesses without a bus cycle.
module lsu_stage
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = LSU_TIMEOUT_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic        i_we,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_stall,
  output logic        o_done,
  output logic [31:0] o_rdata,
  output logic        o_err,
`ifdef LSU_MISALIGN_TRAP_EN
  output logic        o_misaligned,
`endif
  output logic        o_bus_cyc,
  output logic        o_bus_stb,
  output logic        o_bus_we,
  output logic [31:0] o_bus_addr,
  output logic [3:0]  o_bus_sel,
  output logic [31:0] o_bus_wdata,
  input  logic [31:0] i_bus_rdata,
  input  logic        i_bus_ack,
  input  logic        i_bus_err
);

  localparam logic [7:0] TIMEOUT_MAX = TIMEOUT_CYCLES[7:0];

  lsu_state_t  state, state_nxt;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [1:0]  offset_q;
  logic [7:0]  wait_cnt;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        mis_q;
  logic        bus_cyc_q;

  logic        accept;
  logic        legal;
  logic        misaligned;
  logic        go_bus;
  logic        timeout;
  logic [3:0]  sel_nxt;
  logic [31:0] wdata_nxt;
  logic [31:0] load_data;

  assign accept  = i_valid && (state == IDLE);
  assign timeout = (wait_cnt == TIMEOUT_MAX);
  assign go_bus  = legal && !misaligned;

  always_comb begin
    legal = 1'b0;
    case (i_funct3)
      LSU_B, LSU_H, LSU_W: legal = 1'b1;
      LSU_BU, LSU_HU:      legal = !i_we;
      default:             legal = 1'b0;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign misaligned = (((i_funct3 == LSU_H) || (i_funct3 == LSU_HU)) && i_addr[0]) ||
                      ((i_funct3 == LSU_W) && (i_addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  // Store-side lane steering: byte enables and replicated write data.
  always_comb begin
    sel_nxt   = 4'b1111;
    wdata_nxt = i_wdata;
    case (i_funct3)
      LSU_B, LSU_BU: begin
        sel_nxt   = 4'b0001 << i_addr[1:0];
        wdata_nxt = {4{i_wdata[7:0]}};
      end
      LSU_H, LSU_HU: begin
        sel_nxt   = i_addr[1] ? 4'b1100 : 4'b0011;
        wdata_nxt = {2{i_wdata[15:0]}};
      end
      default: begin
        sel_nxt   = 4'b1111;
        wdata_nxt = i_wdata;
      end
    endcase
  end

  lsu_lane_extract u_extract (
    .rdata  (i_bus_rdata),
    .offset (offset_q),
    .funct3 (funct3_q),
    .result (load_data)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = go_bus ? BUS : RESP;
      BUS:     if (i_bus_err || i_bus_ack || timeout) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_ready = (state == IDLE);
    o_done  = (state == RESP);
    o_stall = (state != IDLE) || i_valid;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      we_q        <= 1'b0;
      funct3_q    <= '0;
      offset_q    <= '0;
      wait_cnt    <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      mis_q       <= 1'b0;
      bus_cyc_q   <= 1'b0;
      o_bus_we    <= 1'b0;
      o_bus_addr  <= '0;
      o_bus_sel   <= '0;
      o_bus_wdata <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          we_q        <= i_we;
          funct3_q    <= i_funct3;
          offset_q    <= i_addr[1:0];
          wait_cnt    <= '0;
          rdata_q     <= '0;
          err_q       <= !go_bus;
          mis_q       <= misaligned;
          bus_cyc_q   <= go_bus;
          o_bus_we    <= go_bus && i_we;
          o_bus_sel   <= go_bus ? sel_nxt : 4'b0000;
          o_bus_addr  <= {i_addr[31:2], 2'b00};
          o_bus_wdata <= wdata_nxt;
        end
        BUS: begin
          wait_cnt <= wait_cnt + 8'd1;
          // Error outranks a simultaneous ack; timeout only if neither arrives.
          if (i_bus_err || i_bus_ack || timeout) begin
            bus_cyc_q <= 1'b0;
            o_bus_we  <= 1'b0;
            o_bus_sel <= 4'b0000;
            err_q     <= i_bus_err || !i_bus_ack;
            rdata_q   <= (i_bus_err || !i_bus_ack || we_q) ? 32'h0 : load_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_bus_cyc = bus_cyc_q;
  assign o_bus_stb = bus_cyc_q;
  assign o_rdata   = o_done ? rdata_q : 32'h0;
  assign o_err     = o_done && err_q;
`ifdef LSU_MISALIGN_TRAP_EN
  assign o_misaligned = o_done && mis_q;
`endif

endmodule

// File: doc/lsu_stage.md
# lsu_stage

Load/store unit sitting directly downstream of the execute ALU. Takes the effective address from the ALU's dedicated sum output, plus store data and access size, and runs a single-outstanding Wishbone-style bus transaction. For loads it returns a byte-lane-extracted, sign/zero-extended result, and it holds a stall to the pipeline while the access is in flight. Misaligned accesses and bus errors are reported, never silently dropped.

## Interface
- TIMEOUT_CYCLES, 255: bus cycles in BUS state before the access is aborted as an error (1..255).
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  reset, asynchronous assert, active-low.
- i_valid  in  1  request from execute.
- o_ready  out  1  high only in IDLE; request accepted when i_valid & o_ready.
- i_we  in  1  1 = store, 0 = load.
- i_funct3  in  3  RV32I size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU (stores use 000/001/010).
- i_addr  in  32  effective address (ALU sum).
- i_wdata  in  32  store data, right-aligned (rs2).
- o_stall  out  1  high from acceptance until the cycle o_done is asserted, inclusive.
- o_done  out  1  one-cycle completion pulse.
- o_rdata  out  32  extended load data, valid with o_done; 0 for stores/errors.
- o_err  out  1  with o_done: bus error, timeout, or misalignment.
- o_bus_cyc, o_bus_stb  out  1  transaction active (identical).
- o_bus_we  out  1  write strobe.
- o_bus_addr  out  32  word address, bits [1:0] always 0.
- o_bus_sel  out  4  byte enables.
- o_bus_wdata  out  32  lane-replicated store data.
- i_bus_rdata  in  32  read data.
- i_bus_ack  in  1  transaction complete.
- i_bus_err  in  1  transaction failed.

## Operation
- States: IDLE -> BUS -> RESP -> IDLE; a misaligned access goes IDLE -> RESP directly.
- On accept, the unit latches we, funct3 and addr[1:0], and registers all bus outputs.
- sel values:
  - B: 1 << addr[1:0].
  - H: 0011 or 1100 by addr[1].
  - W: 1111.
- wdata values:
  - B: {4{wdata[7:0]}}.
  - H: {2{wdata[15:0]}}.
  - W: unchanged.
- In BUS, cyc/stb are held until ack or err.
  - i_bus_err has priority over i_bus_ack in the same cycle.
  - When the timeout counter reaches TIMEOUT_CYCLES with neither seen, the access is an error.
  - On any exit from BUS, cyc/stb drop on the next edge.
- Load extraction uses the latched addr[1:0] to pick the byte or halfword. Signed sizes sign-extend from bit 7/15; BU/HU zero-extend.
- RESP drives o_done=1 for one cycle, with o_rdata/o_err from registers. o_ready stays low in RESP, so there are no back-to-back accepts.
- Unsupported funct3 (011, 110, 111, or 100/101 on a store) is treated as an error without bus access: IDLE -> RESP with o_err=1.
- Reset values: state IDLE, o_ready=1, and every other output 0. Reset mid-transaction drops cyc/stb asynchronously; no o_done is produced for the aborted access.

## Timing
- Cycle 0: accept.
- Cycle 1: cyc/stb high.
- Ack sampled at cycle 1+k (k ≥ 0 wait states).
- o_done at cycle 2+k.
- Zero-wait-state load/store latency is 2 cycles accept-to-done. Misaligned or illegal access: o_done at cycle 1.
- Timeout: o_done at cycle 2+TIMEOUT_CYCLES with o_err=1.
- i_bus_ack/i_bus_err are ignored outside BUS.

## Configuration
- LSU_MISALIGN_TRAP_EN defined:
  - H with addr[0]=1, or W with addr[1:0]≠0, raises o_err with no bus cycle.
  - Adds output o_misaligned (1), valid with o_done, so the pipeline can distinguish it from a bus fault.
- LSU_MISALIGN_TRAP_EN undefined:
  - Low address bits are ignored for lane selection of the misaligned part: H uses addr[1], W uses lane 0.
  - The access proceeds on the bus, there is no misalignment error, and the o_misaligned port is absent.

## Structure
- Shared package lsu_pkg holds:
  - state enum lsu_state_t (IDLE, BUS, RESP);
  - funct3 size constants LSU_B/H/W/BU/HU;
  - the default timeout constant.
- One sub-module, lsu_lane_extract: combinational rdata/addr[1:0]/funct3 -> extended 32-bit result. The store-side lane steering stays inline.

## Test plan
- LW at 0x100, ack after 0 waits, rdata 0xDEADBEEF -> o_done at cycle 2, o_rdata=0xDEADBEEF, sel=1111, addr=0x100.
- LB at 0x103, rdata 0x80FFFFFF -> sel=1000, o_rdata=0xFFFFFF80. Same access as LBU -> o_rdata=0x00000080.
- SH at 0x202, wdata 0x1234ABCD -> sel=1100, bus_wdata=0xABCDABCD, we=1, o_rdata=0.
- LH at 0x001:
  - with LSU_MISALIGN_TRAP_EN: o_done at cycle 1, o_err=1, o_misaligned=1, cyc never high;
  - without it: bus access with sel=0011.
- LW with ack and err asserted together after 3 waits -> o_err=1, o_done at cycle 5. LW with no response -> o_err=1 at cycle 2+TIMEOUT_CYCLES.
- Drop i_rst_n while in BUS -> cyc/stb low immediately, o_done never pulses, o_ready=1 after release.
